mem_arbiter: RTL
================

Name: mem_arbiter

Overview:
- Two-requester access controller directly upstream of the single-port memory block.
- Port 0 is the 6502 core bus; port 1 is the loader/debug port.
- Accepts one request at a time over a valid/ready handshake and drives the memory's rd_enable/wr_enable/addr/wr_data for exactly one cycle.
- Waits the memory's fixed read latency, then returns read data to the requester that issued the read.

Parameters:
- DATA_WIDTH, 8, data bus width; matches memory block.
- ADDR_WIDTH, 16, address width; matches memory block.
- RD_LATENCY, 1, cycles from the memory strobe cycle to valid mem_rd_data. 1 = unregistered BRAM output, 2 = output register. Must be >= 1; elaboration error otherwise.

Ports:
- Decided: one clock; reset asynchronous, active-low.
- clk  in  1  system clock; all state on rising edge.
- reset  in  1  asynchronous active-low reset (0 = in reset).
- req0_valid  in  1  port 0 request valid.
- req0_ready  out  1  port 0 request accepted this cycle when high together with req0_valid.
- req0_we  in  1  port 0: 1 = write, 0 = read.
- req0_addr  in  ADDR_WIDTH  port 0 address.
- req0_wdata  in  DATA_WIDTH  port 0 write data.
- rsp0_valid  out  1  one-cycle pulse: rsp_rdata holds port 0 read data.
- req1_valid, req1_ready, req1_we, req1_addr, req1_wdata, rsp1_valid: same as port 0, for port 1.
- rsp_rdata  out  DATA_WIDTH  registered read data; shared by both ports.
- mem_rd_enable  out  1  to memory rd_enable.
- mem_wr_enable  out  1  to memory wr_enable.
- mem_addr  out  ADDR_WIDTH  to memory addr.
- mem_wr_data  out  DATA_WIDTH  to memory wr_data.
- mem_rd_data  in  DATA_WIDTH  from memory rd_data.

Behaviour:
- Reset (async assert, sync release): state IDLE; all outputs 0; wait counter 0; round-robin pointer = port 1, so port 0 wins first. Any transaction in flight is dropped and no rsp is produced.
- States and transitions:
  - IDLE -> ISSUE on acceptance.
  - ISSUE -> IDLE for a write.
  - ISSUE -> WAIT for a read.
  - WAIT -> IDLE after RD_LATENCY cycles.
- IDLE, grant selection:
  - Grant is computed combinationally from req0_valid and req1_valid.
  - reqN_ready = (state == IDLE) && grant == N. Ready is never high for both ports.
  - Acceptance at cycle T registers addr, we and wdata into mem_addr/mem_wr_data and records the granted port.
- ISSUE (cycle T+1):
  - Exactly one of mem_rd_enable or mem_wr_enable is high, for this cycle only.
  - Both strobes are low in every other state.
  - mem_addr and mem_wr_data hold their last values outside ISSUE.
- WAIT (cycles T+2 .. T+1+RD_LATENCY):
  - Counter loads RD_LATENCY and decrements once per cycle.
  - On the last WAIT cycle: sample mem_rd_data into rsp_rdata, set rspN_valid for the recorded port, go to IDLE.
- Read latency, acceptance to rspN_valid: RD_LATENCY+2 cycles (3 for default).
  - rspN_valid is high for exactly one cycle.
  - rsp_rdata holds its value until the next read completes.
  - There is no response backpressure.
- Writes produce no rsp.
- Throughput:
  - One write per 2 cycles.
  - One read per RD_LATENCY+2 cycles.
  - A new acceptance may occur in the same cycle rspN_valid is high.
- Requester rules:
  - A requester holds valid, we, addr and wdata stable until ready.
  - Dropping valid before ready is permitted and simply cancels the request.
- Simultaneous valid on both ports: resolved by the grant rule (see Optional Feature); exactly one is accepted.
- Address and data are forwarded unmodified; no wrap or width conversion.

Optional Feature:
- Macro: MEM_ARBITER_RR_EN.
- Defined:
  - Round-robin arbitration; a 1-bit last-grant pointer updates on each acceptance.
  - When both ports are valid, the port not last granted wins.
  - A single valid port is always granted.
- Undefined: fixed priority, port 0 always wins over port 1; no pointer flop is present.

Decomposition:
- Package mem_arbiter_pkg:
  - State enum (IDLE, ISSUE, WAIT).
  - Port index localparams PORT_CPU = 0, PORT_AUX = 1.
  - Default RD_LATENCY constant.
- One sub-module is natural: mem_arbiter_grant. It holds the combinational grant plus the optional round-robin pointer flop and is the only place MEM_ARBITER_RR_EN is tested.
- The FSM, counter and datapath stay in mem_arbiter.

Test Plan:
- Reset: hold reset=0 with req0_valid=1 -> all outputs 0, req0_ready=0. Release -> req0_ready=1 in the first IDLE cycle.
- Port 0 write addr 0x1234, data 0xA5 -> mem_wr_enable=1, mem_addr=0x1234, mem_wr_data=0xA5 for exactly the cycle after acceptance. No rsp0_valid. Ready again 2 cycles after acceptance.
- Port 1 read of 0x1234 after that write, with a memory model at RD_LATENCY=1 and =2 -> rsp1_valid pulses 3 and 4 cycles after acceptance, rsp_rdata=0xA5, rsp0_valid stays 0.
- Both ports valid continuously (reads of 0x0010 and 0x0020):
  - Fixed: port 0 always granted; port 1 starves.
  - With MEM_ARBITER_RR_EN: grants alternate 0,1,0,1 and rsp pulses alternate accordingly.
- Reset asserted during WAIT of a read -> rsp0_valid and rsp1_valid never pulse for that read; state is IDLE after release.
- Requester drops req0_valid before ready (port 1 busy) -> no memory strobe is issued for port 0.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the two-port memory arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mem_arbiter_pkg;

  // Controller phases: wait for a request, strobe the memory, wait out read latency.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  // Port indices; a grant is a single bit holding one of these.
  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_AUX = 1'b1;

  // Unregistered BRAM output: data valid the cycle after the strobe.
  localparam int RD_LATENCY_DEF = 1;

endpackage

// File: rtl/mem_arbiter_grant.sv
// Grant selection between the 6502 core port (0) and the loader/debug port (1).
// Latency: combinational grant; pointer (when present) updates on acceptance.
// Backpressure: none; the caller qualifies the grant with its own idle state.
//
// Ports:
//   clk, reset            clock, async active-low reset (pointer only)
//   req0_valid/req1_valid request valids from both ports
//   accept                high in the cycle a request is taken
//   grant                 winning port index (PORT_CPU when nobody asks)
//
// Build option: MEM_ARBITER_RR_EN selects round-robin; otherwise port 0 has
// fixed priority and no pointer flop exists.
module mem_arbiter_grant
  import mem_arbiter_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic req0_valid,
  input  logic req1_valid,
  input  logic accept,
  output logic grant
);

`ifdef MEM_ARBITER_RR_EN
  logic last_grant;

  // Reset to the aux port so the core port wins the first contested cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_grant <= PORT_AUX;
    end else if (accept) begin
      last_grant <= grant;
    end
  end

  always_comb begin
    grant = PORT_CPU;
    if (req0_valid && req1_valid) begin
      grant = ~last_grant;
    end else if (req1_valid) begin
      grant = PORT_AUX;
    end
  end
`else
  // Fixed priority needs no state; these inputs exist only for the RR build.
  logic unused_rr;
  assign unused_rr = ^{clk, reset, accept};

  always_comb begin
    grant = PORT_CPU;
    if (!req0_valid && req1_valid) begin
      grant = PORT_AUX;
    end
  end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester controller in front of a single-port memory; one access at a time.
// Latency: write strobe 1 cycle after acceptance; read rsp RD_LATENCY+2 cycles after.
// Backpressure: reqN_ready low while a transaction is in flight; no rsp backpressure.
//
// Ports:
//   clk, reset                       clock, async active-low reset
//   reqN_valid/ready/we/addr/wdata   request handshake, N = 0 (core), 1 (loader)
//   rspN_valid                       one-cycle pulse, rsp_rdata holds port N read data
//   rsp_rdata                        registered read data shared by both ports
//   mem_rd_enable/mem_wr_enable      one-cycle memory strobes
//   mem_addr/mem_wr_data/mem_rd_data memory address and data
//
// Build option: MEM_ARBITER_RR_EN (round-robin grant, see mem_arbiter_grant).
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 16,
  parameter int RD_LATENCY = RD_LATENCY_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req0_valid,
  output logic                  req0_ready,
  input  logic                  req0_we,
  input  logic [ADDR_WIDTH-1:0] req0_addr,
  input  logic [DATA_WIDTH-1:0] req0_wdata,
  output logic                  rsp0_valid,
  input  logic                  req1_valid,
  output logic                  req1_ready,
  input  logic                  req1_we,
  input  logic [ADDR_WIDTH-1:0] req1_addr,
  input  logic [DATA_WIDTH-1:0] req1_wdata,
  output logic                  rsp1_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  mem_rd_enable,
  output logic                  mem_wr_enable,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wr_data,
  input  logic [DATA_WIDTH-1:0] mem_rd_data
);

  localparam int CNT_W = (RD_LATENCY < 1) ? 1 : $clog2(RD_LATENCY + 1);

  generate
    if (RD_LATENCY < 1) begin : g_bad_latency
      $error("mem_arbiter: RD_LATENCY must be >= 1");
    end
  endgenerate

  state_t           state;
  logic [CNT_W-1:0] wait_cnt;
  logic             port_q;
  logic             we_q;
  logic             grant;
  logic             idle;
  logic             accept;

  // Ready is gated by reset directly so both readys read 0 while reset is held.
  assign idle       = (state == IDLE) && reset;
  assign req0_ready = idle && (grant == PORT_CPU);
  assign req1_ready = idle && (grant == PORT_AUX);
  assign accept     = (req0_ready && req0_valid) || (req1_ready && req1_valid);

  mem_arbiter_grant u_grant (
    .clk        (clk),
    .reset      (reset),
    .req0_valid (req0_valid),
    .req1_valid (req1_valid),
    .accept     (accept),
    .grant      (grant)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      wait_cnt      <= '0;
      port_q        <= PORT_CPU;
      we_q          <= 1'b0;
      mem_rd_enable <= 1'b0;
      mem_wr_enable <= 1'b0;
      mem_addr      <= '0;
      mem_wr_data   <= '0;
      rsp0_valid    <= 1'b0;
      rsp1_valid    <= 1'b0;
      rsp_rdata     <= '0;
    end else begin
      // Strobes and rsp pulses are single-cycle unless re-set below.
      mem_rd_enable <= 1'b0;
      mem_wr_enable <= 1'b0;
      rsp0_valid    <= 1'b0;
      rsp1_valid    <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            state  <= ISSUE;
            port_q <= grant;
            // Strobes are registered here so they are high exactly in ISSUE.
            if (grant == PORT_AUX) begin
              mem_addr      <= req1_addr;
              mem_wr_data   <= req1_wdata;
              we_q          <= req1_we;
              mem_wr_enable <= req1_we;
              mem_rd_enable <= ~req1_we;
            end else begin
              mem_addr      <= req0_addr;
              mem_wr_data   <= req0_wdata;
              we_q          <= req0_we;
              mem_wr_enable <= req0_we;
              mem_rd_enable <= ~req0_we;
            end
          end
        end
        ISSUE: begin
          if (we_q) begin
            state <= IDLE;
          end else begin
            state    <= WAIT;
            wait_cnt <= CNT_W'(RD_LATENCY);
          end
        end
        WAIT: begin
          if (wait_cnt == CNT_W'(1)) begin
            state      <= IDLE;
            wait_cnt   <= '0;
            rsp_rdata  <= mem_rd_data;
            rsp0_valid <= (port_q == PORT_CPU);
            rsp1_valid <= (port_q == PORT_AUX);
          end else begin
            wait_cnt <= wait_cnt - CNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
